sub_serial: RTL and testbench
=============================

// Module: sub_serial
// PURPOSE
//  Bit-serial subtractor, the inverse counterpart to the team's bit-serial adder.
//  - Captures parallel operands a and b, computes out = a - b (mod 2^WIDTH) LSB-first, one bit per clock.
//  - Reports the final borrow.
//  - Sits beside add_serial in the serial-arithmetic datapath; same en/done-style control.
// PARAMETERS
//  WIDTH  8  Operand and result width in bits (>=2). Sets the number of SUB cycles.
// PORTS
//  clk     in   1      Single clock; all state changes on its rising edge.
//  rst     in   1      Synchronous, active-low reset.
//  en      in   1      Start request (IDLE) / acknowledge-and-release (DONE).
//  a       in   WIDTH  Minuend, sampled only on the load edge.
//  b       in   WIDTH  Subtrahend, sampled only on the load edge.
//  out     out  WIDTH  Difference register (shift register, MSB-inserted).
//  borrow  out  1      Final borrow. 1 means a < b. Valid while done=1.
//  done    out  1      High exactly while state==DONE.
// BEHAVIOUR
//  - Reset: on a clk edge with rst=0, the following are cleared, overriding everything else:
//    - state=IDLE, out=0, borrow=0, done=0
//    - internal a_reg=0, b_reg=0, brw=0, count=0
//    - en is ignored while rst=0.
//  - Internal registers:
//    - a_reg, b_reg: WIDTH bits.
//    - brw: 1 bit.
//    - count: $clog2(WIDTH) bits; wraps modulo 2^bits, and is only compared against WIDTH-1.
//  - States: IDLE(0), SUB(1), DONE(2). Encoding is 2 bits; unused codes return to IDLE.
//  - IDLE:
//    - en=1: a_reg<=a, b_reg<=b, brw<=0, count<=0, out<=0, go to SUB.
//    - en=0: all registers hold.
//  - SUB (one bit per edge):
//    - d = a_reg[0]^b_reg[0]^brw
//    - out <= {d, out[WIDTH-1:1]}
//    - a_reg <= a_reg>>1, b_reg <= b_reg>>1
//    - brw <= (~a_reg[0]&b_reg[0]) | (~(a_reg[0]^b_reg[0])&brw)
//    - count <= count+1
//    - If count==WIDTH-1: borrow <= next brw, go to DONE; otherwise stay in SUB.
//    - en, a and b are ignored throughout SUB (no restart, no abort).
//  - DONE:
//    - out and borrow hold; done=1.
//    - en=1: go to IDLE. out/borrow are retained until the next load.
//    - en=0: stay in DONE.
//  - Latency: with the load on edge L, SUB occupies edges L+1..L+WIDTH. done=1 and out is valid after edge L+WIDTH.
//  - Back-to-back operation: DONE->IDLE takes 1 edge and IDLE->SUB 1 edge, so the minimum period is WIDTH+2 edges.
//  - done is decoded from state with no extra register stage, so it is 0 in the same cycle the state leaves DONE.
//  - Arithmetic is modular 2^WIDTH. Full borrow ripple is supported (e.g. 0-1).
// CONFIGURATION
//  SUB_SERIAL_SAT_EN
//  - Defined: on the SUB->DONE edge, if the final borrow is 1, out <= 0 instead of the last shifted value.
//    borrow still reads 1, i.e. saturating (floor-at-zero) unsigned subtract.
//  - Undefined: out always holds the modular difference. No extra logic.
// TESTING
//  1. Reset, then a=200, b=55, en=1 for 1 cycle -> done=1 exactly 8 edges after the load edge; out=145, borrow=0.
//  2. a=5, b=10 -> macro off: out=8'hFB, borrow=1. SUB_SERIAL_SAT_EN: out=8'h00, borrow=1.
//  3. a=0, b=1 -> out=8'hFF, borrow=1 (macro off). a=b=8'hA5 -> out=0, borrow=0.
//  4. Hold en=1 and toggle a/b every cycle during SUB:
//     - result equals the values captured at load.
//     - In DONE with en=1, the next edge gives IDLE, the following edge reloads.
//     - done stays 0 for 8 edges.
//  5. Drive rst=0 on the 4th SUB edge -> next edge: state=IDLE, out=0, borrow=0, done=0.
//     Hold rst=0 with en=1 -> no load occurs.
//  6. WIDTH=4 instance, a=4'h3, b=4'h9 -> done after 4 SUB edges; out=4'hA, borrow=1.

Source files
------------

// File: rtl/sub_serial.sv
// Bit-serial subtractor: loads a and b, produces out = a - b (mod 2^WIDTH) LSB-first, one bit per clock.
// Optional SUB_SERIAL_SAT_EN floors the result at zero when the final borrow is set.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;

  logic             diff_bit;
  logic             brw_nxt;

  // Full-subtractor slice on the current LSBs
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
    brw_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          a_d     = a;
          b_d     = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          out_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        out_d = {diff_bit, out_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          borrow_d = brw_nxt;
          state_d  = DONE;
`ifdef SUB_SERIAL_SAT_EN
          if (brw_nxt) out_d = '0;
`endif
        end
      end
      DONE: begin
        if (en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
    end
  end

  // done is a pure decode of state so it drops on the same edge DONE is left
  assign done   = (state_q == DONE);
  assign out    = out_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_serial.sv
// Randomized self-checking bench for sub_serial (WIDTH=8 and WIDTH=4 instances)
// against an arithmetic reference model of unsigned subtraction.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] a, b;
  logic [7:0] out;
  logic       borrow, done;

  logic       en4;
  logic [3:0] a4, b4;
  logic [3:0] out4;
  logic       borrow4, done4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sub_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .out(out), .borrow(borrow), .done(done)
  );

  sub_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .a(a4), .b(b4),
    .out(out4), .borrow(borrow4), .done(done4)
  );

  // Reference: unsigned difference modulo 2^w, borrow when minuend < subtrahend
  function automatic int model_diff(int x, int y, int w);
    int r;
    r = (x - y) & ((1 << w) - 1);
`ifdef SUB_SERIAL_SAT_EN
    if (x < y) r = 0;
`endif
    return r;
  endfunction

  function automatic int model_brw(int x, int y);
    return (x < y) ? 1 : 0;
  endfunction

  // Loads x,y from IDLE and waits for done; lat = edges from load to done (-1 on timeout).
  // With hold set, en stays high and a/b are scrambled every cycle during SUB.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit hold, output int lat);
    a  = x;
    b  = y;
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (hold) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic ack();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; a = 8'd200; b = 8'd55;
    en4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out !== 8'd0 || borrow !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%0h borrow=%0b done=%0b required 0/0/0", out, borrow, done);
    end
    rst = 1'b1; en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int lat;
    logic [7:0] xs [4] = '{8'd200, 8'd5, 8'd0, 8'hA5};
    logic [7:0] ys [4] = '{8'd55, 8'd10, 8'd1, 8'hA5};
    for (int k = 0; k < 4; k++) begin
      run_op(xs[k], ys[k], 1'b0, lat);
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL latency[%0d]: got %0d required 8", k, lat);
      end
      total++;
      if (int'(out) !== model_diff(xs[k], ys[k], 8) || int'(borrow) !== model_brw(xs[k], ys[k])) begin
        bad++;
        $display("FAIL directed[%0d] %0d-%0d: out=%0h borrow=%0b required %0h/%0d", k, xs[k], ys[k],
                 out, borrow, model_diff(xs[k], ys[k], 8), model_brw(xs[k], ys[k]));
      end
      ack();
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] x, y, held;
    for (int k = 0; k < 30; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (k % 5 == 0) y = x + 8'd1;
      run_op(x, y, 1'b0, lat);
      total++;
      if (lat !== 8 || int'(out) !== model_diff(x, y, 8) || int'(borrow) !== model_brw(x, y)) begin
        bad++;
        $display("FAIL random[%0d] %0d-%0d: lat=%0d out=%0h borrow=%0b required 8/%0h/%0d", k, x, y,
                 lat, out, borrow, model_diff(x, y, 8), model_brw(x, y));
      end
      held = out;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1 || out !== held) begin
        bad++;
        $display("FAIL done_hold[%0d]: done=%0b out=%0h required 1/%0h", k, done, out, held);
      end
      ack();
      total++;
      if (done !== 1'b0 || out !== held) begin
        bad++;
        $display("FAIL ack[%0d]: done=%0b out=%0h required 0/%0h", k, done, out, held);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] x, y, held;
    x = 8'd77; y = 8'd190;
    run_op(x, y, 1'b1, lat);
    total++;
    if (lat !== 8 || int'(out) !== model_diff(x, y, 8) || int'(borrow) !== model_brw(x, y)) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d out=%0h borrow=%0b required 8/%0h/%0d", lat, out, borrow,
               model_diff(x, y, 8), model_brw(x, y));
    end
    held = out;
    x = 8'd250; y = 8'd3;
    a = x; b = y;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || out !== held) begin
      bad++;
      $display("FAIL b2b_idle: done=%0b out=%0h required 0/%0h", done, out, held);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || out !== 8'd0) begin
      bad++;
      $display("FAIL b2b_reload: done=%0b out=%0h required 0/0", done, out);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    en = 1'b0;
    total++;
    if (lat !== 8 || int'(out) !== model_diff(x, y, 8) || int'(borrow) !== model_brw(x, y)) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d out=%0h borrow=%0b required 8/%0h/%0d", lat, out, borrow,
               model_diff(x, y, 8), model_brw(x, y));
    end
    ack();
  endtask

  task automatic test_mid_reset();
    int lat;
    run_op(8'd3, 8'd9, 1'b0, lat);
    ack();
    a = 8'd0; b = 8'd1; en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'd0 || borrow !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: out=%0h borrow=%0b done=%0b required 0/0/0", out, borrow, done);
    end
    en = 1'b1; a = 8'hFF; b = 8'h00;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (out !== 8'd0 || borrow !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_load: out=%0h borrow=%0b done=%0b required 0/0/0", out, borrow, done);
    end
    en = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(8'd100, 8'd37, 1'b0, lat);
    total++;
    if (lat !== 8 || out !== 8'd63 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: lat=%0d out=%0h borrow=%0b required 8/3f/0", lat, out, borrow);
    end
    ack();
  endtask

  task automatic test_width4();
    int lat;
    logic [3:0] x, y;
    for (int k = 0; k < 8; k++) begin
      x = (k == 0) ? 4'h3 : 4'($urandom);
      y = (k == 0) ? 4'h9 : 4'($urandom);
      a4 = x; b4 = y; en4 = 1'b1;
      @(posedge clk);
      #1;
      en4 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
        @(posedge clk);
        #1;
        if (done4) begin
          lat = i;
          break;
        end
      end
      total++;
      if (lat !== 4 || int'(out4) !== model_diff(x, y, 4) || int'(borrow4) !== model_brw(x, y)) begin
        bad++;
        $display("FAIL width4[%0d] %0d-%0d: lat=%0d out=%0h borrow=%0b required 4/%0h/%0d", k, x, y,
                 lat, out4, borrow4, model_diff(x, y, 4), model_brw(x, y));
      end
      en4 = 1'b1;
      @(posedge clk);
      #1;
      en4 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; a = '0; b = '0;
    en4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
